// File: rtl/bcd_render_pkg.sv
// Shared constants and font data for the BCD digit readout.
package bcd_render_pkg;

    localparam int GLYPH_W    = 3;
    localparam int GLYPH_H    = 5;
    localparam int CELL_W     = 4;
    localparam int CELL_H     = 6;
    localparam int NUM_DIGITS = 4;

    // One glyph: 5 rows of 3 bits, row 0 in [14:12], MSB of a row = leftmost column.
    typedef logic [GLYPH_W*GLYPH_H-1:0] glyph_t;

    localparam glyph_t FONT_0 = 15'b111_101_101_101_111;
    localparam glyph_t FONT_1 = 15'b010_110_010_010_111;
    localparam glyph_t FONT_2 = 15'b111_001_111_100_111;
    localparam glyph_t FONT_3 = 15'b111_001_111_001_111;
    localparam glyph_t FONT_4 = 15'b101_101_111_001_001;
    localparam glyph_t FONT_5 = 15'b111_100_111_001_111;
    localparam glyph_t FONT_6 = 15'b111_100_111_101_111;
    localparam glyph_t FONT_7 = 15'b111_001_001_001_001;
    localparam glyph_t FONT_8 = 15'b111_101_111_101_111;
    localparam glyph_t FONT_9 = 15'b111_101_111_001_111;

    // Non-decimal codes map to an empty glyph.
    function automatic glyph_t font_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    return FONT_0;
            4'd1:    return FONT_1;
            4'd2:    return FONT_2;
            4'd3:    return FONT_3;
            4'd4:    return FONT_4;
            4'd5:    return FONT_5;
            4'd6:    return FONT_6;
            4'd7:    return FONT_7;
            4'd8:    return FONT_8;
            4'd9:    return FONT_9;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_render_if.sv
// Digit capture, frame timing and pixel-coordinate bundle for the readout.
interface bcd_digit_render_if;

    logic       ready;
    logic [3:0] dig_1;
    logic [3:0] dig_2;
    logic [3:0] dig_3;
    logic [3:0] dig_4;
    logic       frame_start;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pixel_on;

    // Source side: BCD converter, video timing and the colour mux.
    modport master (
        output ready, dig_1, dig_2, dig_3, dig_4, frame_start, hpos, vpos,
        input  pixel_on
    );

    // Renderer side.
    modport slave (
        input  ready, dig_1, dig_2, dig_3, dig_4, frame_start, hpos, vpos,
        output pixel_on
    );

endinterface

// File: rtl/digit_font_rom.sv
// Combinational 3x5 font lookup: one glyph row per digit, blank outside 0..9 / rows 0..4.
module digit_font_rom
    import bcd_render_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [2:0] bits
);

    glyph_t glyph;

    // Pick the row slice of the selected glyph.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        bits  = 3'b000;
        glyph = font_glyph(digit);
        case (row)
            3'd0:    bits = glyph[14:12];
            3'd1:    bits = glyph[11:9];
            3'd2:    bits = glyph[8:6];
            3'd3:    bits = glyph[5:3];
            3'd4:    bits = glyph[2:0];
            default: bits = 3'b000;
        endcase
    end

endmodule

// File: rtl/bcd_digit_render.sv
// Four-digit decimal readout overlay: double-buffered digits, 2-stage pixel pipeline.
module bcd_digit_render
    import bcd_render_pkg::*;
#(
    parameter int unsigned X0         = 256,
    parameter int unsigned Y0         = 200,
    parameter int unsigned SCALE_LOG2 = 3,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    bcd_digit_render_if.slave bus
);

    localparam logic [9:0] X0_V  = 10'(X0);
    localparam logic [9:0] Y0_V  = 10'(Y0);
    localparam logic [9:0] BOX_W = 10'((CELL_W * NUM_DIGITS) << SCALE_LOG2);
    localparam logic [9:0] BOX_H = 10'(CELL_H << SCALE_LOG2);

    // Digits packed {dig_4, dig_3, dig_2, dig_1}; dig_4 is leftmost.
    logic [15:0] incoming;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] disp_q, disp_d;

    // Stage 1: box test and cell/glyph coordinates.
    logic [9:0] rel_x, rel_y;
    logic       s1_in_box_q, s1_in_box_d;
    logic [1:0] s1_idx_q, s1_idx_d;
    logic [1:0] s1_col_q, s1_col_d;
    logic [2:0] s1_row_q, s1_row_d;

    // Stage 2: glyph lookup and blanking.
    logic [3:0] cur_digit;
    logic [2:0] font_bits;
    logic       font_bit;
    logic       gap;
    logic       blank;
    logic       pixel_on_q, pixel_on_d;

    assign incoming = {bus.dig_4, bus.dig_3, bus.dig_2, bus.dig_1};

    // Capture on ready; swap to display at frame start, bypassing if both coincide.
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        if (bus.ready) begin
            shadow_d = incoming;
        end
        if (bus.frame_start) begin
            disp_d = bus.ready ? incoming : shadow_q;
        end
    end

    // Position relative to the box and decomposition into digit/column/row.
    always_comb begin
        rel_x       = bus.hpos - X0_V;
        rel_y       = bus.vpos - Y0_V;
        // Raw compares against X0/Y0 reject coordinates that wrap below the box edge.
        s1_in_box_d = (bus.hpos >= X0_V) && (rel_x < BOX_W) &&
                      (bus.vpos >= Y0_V) && (rel_y < BOX_H);
        s1_idx_d    = rel_x[SCALE_LOG2+2 +: 2];
        s1_col_d    = rel_x[SCALE_LOG2 +: 2];
        s1_row_d    = rel_y[SCALE_LOG2 +: 3];
    end

    digit_font_rom u_font (
        .digit (cur_digit),
        .row   (s1_row_q),
        .bits  (font_bits)
    );

    // Select the displayed digit, apply gap/blanking rules and pick the font column.
    always_comb begin
        cur_digit = disp_q[3:0];
        blank     = 1'b0;
        case (s1_idx_q)
            2'd0: begin
                cur_digit = disp_q[15:12];
                blank     = BLANK_LZ && (disp_q[15:12] == 4'd0);
            end
            2'd1: begin
                cur_digit = disp_q[11:8];
                blank     = BLANK_LZ && (disp_q[15:8] == 8'd0);
            end
            2'd2: begin
                cur_digit = disp_q[7:4];
                blank     = BLANK_LZ && (disp_q[15:4] == 12'd0);
            end
            default: begin
                cur_digit = disp_q[3:0];
                blank     = 1'b0;
            end
        endcase
        if (cur_digit > 4'd9) begin
            blank = 1'b1;
        end

        gap = (s1_col_q == 2'd3) || (s1_row_q >= 3'(GLYPH_H));

        case (s1_col_q)
            2'd0:    font_bit = font_bits[2];
            2'd1:    font_bit = font_bits[1];
            2'd2:    font_bit = font_bits[0];
            default: font_bit = 1'b0;
        endcase

        pixel_on_d = s1_in_box_q && !gap && !blank && font_bit;
    end

    // Digit buffers and both pipeline stages, all cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            disp_q      <= '0;
            s1_in_box_q <= 1'b0;
            s1_idx_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            pixel_on_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values and stages stay aligned.
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            s1_in_box_q <= s1_in_box_d;
            s1_idx_q    <= s1_idx_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            pixel_on_q  <= pixel_on_d;
        end
    end

    assign bus.pixel_on = pixel_on_q;

endmodule

// File: tb/tb_bcd_digit_render.sv
// Directed self-checking bench for the BCD digit readout.
module tb_bcd_digit_render;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    bcd_digit_render_if bus_if ();

    bcd_digit_render dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int x, input int y);
        bus_if.hpos = 10'(x);
        bus_if.vpos = 10'(y);
    endtask

    // Present a coordinate and check pixel_on exactly two edges later.
    task automatic probe(input string tag, input int x, input int y, input logic exp);
        set_pos(x, y);
        tick(2);
        check(tag, bus_if.pixel_on, exp);
    endtask

    // One-cycle ready pulse, optionally coincident with frame_start.
    task automatic send(input logic [3:0] d4, input logic [3:0] d3,
                        input logic [3:0] d2, input logic [3:0] d1, input logic fs);
        bus_if.dig_4       = d4;
        bus_if.dig_3       = d3;
        bus_if.dig_2       = d2;
        bus_if.dig_1       = d1;
        bus_if.ready       = 1'b1;
        bus_if.frame_start = fs;
        tick(1);
        bus_if.ready       = 1'b0;
        bus_if.frame_start = 1'b0;
    endtask

    task automatic frame();
        bus_if.frame_start = 1'b1;
        tick(1);
        bus_if.frame_start = 1'b0;
    endtask

    initial begin
        n_checks           = 0;
        n_errors           = 0;
        reset              = 1'b1;
        bus_if.ready       = 1'b0;
        bus_if.frame_start = 1'b0;
        bus_if.dig_1       = '0;
        bus_if.dig_2       = '0;
        bus_if.dig_3       = '0;
        bus_if.dig_4       = '0;
        set_pos(352, 200);

        // Reset held while scanning a lit position.
        tick(3);
        check("rst_hold", bus_if.pixel_on, 1'b0);
        reset = 1'b0;
        tick(1);
        check("rst_first_edge", bus_if.pixel_on, 1'b0);
        tick(1);
        check("rst_zero_dig1", bus_if.pixel_on, 1'b1);
        probe("rst_dig4_dark", 256, 200, 1'b0);

        // Leading-zero blanking: 0042; display must wait for frame_start.
        send(4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
        probe("lz_before_swap", 320, 200, 1'b0);
        frame();
        probe("lz_dig4", 256, 200, 1'b0);
        probe("lz_dig3", 288, 200, 1'b0);
        probe("lz_4_col0", 320, 200, 1'b1);
        probe("lz_4_col1", 328, 200, 1'b0);
        probe("lz_2_col0", 352, 200, 1'b1);
        probe("lz_out_right", 384, 200, 1'b0);

        // Tearing guard: new value held off until the next frame.
        send(4'd0, 4'd0, 4'd7, 4'd7, 1'b0);
        probe("tear_hold", 328, 200, 1'b0);
        probe("tear_hold2", 328, 200, 1'b0);
        frame();
        probe("tear_swap", 328, 200, 1'b1);

        // Reset mid-frame on a lit pixel clears output at once and the display.
        set_pos(320, 200);
        tick(2);
        check("mid_lit", bus_if.pixel_on, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_async_clear", bus_if.pixel_on, 1'b0);
        tick(2);
        check("mid_hold", bus_if.pixel_on, 1'b0);
        reset = 1'b0;
        tick(2);
        check("mid_disp_cleared", bus_if.pixel_on, 1'b0);
        probe("mid_zero_dig1", 352, 200, 1'b1);

        // Simultaneous ready and frame_start bypass into the display.
        send(4'd0, 4'd0, 4'd0, 4'd1, 1'b1);
        probe("byp_1_r1c1", 360, 208, 1'b1);
        probe("byp_1_r1c0", 352, 208, 1'b1);
        probe("byp_1_r1c2", 368, 208, 1'b0);
        frame();
        probe("byp_shadow", 360, 208, 1'b1);

        // Interior zero is shown once a higher digit is non-zero.
        send(4'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        probe("lz_mid_dig4", 256, 200, 1'b0);
        probe("lz_mid_dig3", 288, 200, 1'b1);
        probe("lz_mid_dig2", 320, 200, 1'b1);

        // Invalid digit renders blank.
        send(4'd0, 4'd0, 4'd0, 4'hA, 1'b1);
        probe("inv_r0c0", 352, 200, 1'b0);
        probe("inv_r0c1", 360, 200, 1'b0);
        probe("inv_r1c1", 360, 208, 1'b0);
        probe("inv_r4c2", 368, 232, 1'b0);

        // Eights everywhere: gaps and box edges.
        send(4'd8, 4'd8, 4'd8, 4'd8, 1'b1);
        probe("g8_dig4", 256, 200, 1'b1);
        probe("g8_dig2_c2", 336, 200, 1'b1);
        probe("g8_gap_col", 344, 200, 1'b0);
        probe("g8_gap_col_hi", 351, 200, 1'b0);
        probe("g8_row4", 352, 239, 1'b1);
        probe("g8_gap_row", 352, 240, 1'b0);
        probe("g8_vpos_y0p47", 352, 247, 1'b0);
        probe("g8_below_box", 352, 248, 1'b0);
        probe("g8_above_box", 352, 199, 1'b0);
        probe("g8_x0_minus1", 255, 200, 1'b0);
        probe("g8_hpos0", 0, 200, 1'b0);
        probe("g8_last_c2", 375, 200, 1'b1);
        probe("g8_last_gap", 376, 200, 1'b0);
        probe("g8_hpos1023", 1023, 200, 1'b0);

        // Latency: exactly two edges on a step into and out of the box.
        set_pos(0, 200);
        tick(3);
        set_pos(256, 200);
        tick(1);
        check("lat_in_1edge", bus_if.pixel_on, 1'b0);
        tick(1);
        check("lat_in_2edge", bus_if.pixel_on, 1'b1);
        set_pos(0, 200);
        tick(1);
        check("lat_out_1edge", bus_if.pixel_on, 1'b1);
        tick(1);
        check("lat_out_2edge", bus_if.pixel_on, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_digit_render.md
Name: bcd_digit_render

Overview:
- Downstream consumer of the binary-to-BCD converter (`bcd`). Captures its four BCD digits on `ready` and renders them as a 4-digit decimal readout at a fixed screen position on the 6-bit VGA output.
- Given the current pixel coordinate, produces a registered `pixel_on` that the colour mux ORs into the RGB path.
- Double-buffers the digits so the value only changes at frame start, which prevents tearing.

Parameters:
- X0, 256: left edge of the readout box, in pixels.
- Y0, 200: top edge of the readout box, in pixels.
- SCALE_LOG2, 3: each font pixel is drawn as a (1<<SCALE_LOG2)-square block of screen pixels.
- BLANK_LZ, 1: when 1, leading zeros are blanked; dig_1 is always shown.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  single-cycle pulse from `bcd`; dig_1..dig_4 are valid in this cycle
- dig_1  in  4  BCD ones digit
- dig_2  in  4  BCD tens digit
- dig_3  in  4  BCD hundreds digit
- dig_4  in  4  BCD thousands digit (leftmost on screen)
- frame_start  in  1  single-cycle pulse at the start of vertical blanking
- hpos  in  10  current pixel x
- vpos  in  10  current pixel y
- pixel_on  out  1  readout pixel lit, 2 cycles after hpos/vpos

Behaviour:
- Reset (async, active-high):
  - Clears the shadow digit registers, the display digit registers and both pipeline stages.
  - pixel_on = 0 while reset is asserted and on the first edges after release, until valid data reaches stage 2.
- Capture:
  - On ready, shadow <= {dig_4, dig_3, dig_2, dig_1}.
  - The display registers do not change on ready.
- Swap:
  - On frame_start, display <= shadow.
  - If ready and frame_start occur in the same cycle, display <= the incoming dig_4..dig_1 (bypass), and shadow takes the same value.
  - If frame_start arrives with no new ready, display is reloaded with an unchanged value; this is harmless.
- Geometry:
  - Glyph is 3 columns x 5 rows inside a 4x6 cell; cell column 3 and cell row 5 are always-off gaps.
  - The box is 4 cells wide and 1 cell tall: width = 16<<SCALE_LOG2, height = 6<<SCALE_LOG2.
- Stage 1 (registered):
  - rel_x = hpos - X0 and rel_y = vpos - Y0, 10-bit.
  - in_box = (hpos >= X0) && (rel_x < width) && (vpos >= Y0) && (rel_y < height). The unsigned compare on raw hpos must catch wrap-around below X0.
  - cx = rel_x >> SCALE_LOG2; digit index = cx[3:2] (0 selects dig_4, 3 selects dig_1); glyph column = cx[1:0].
  - glyph row = rel_y >> SCALE_LOG2.
  - Register in_box, digit index, glyph column and glyph row.
- Stage 2 (registered):
  - Select the display digit and look up its font row.
  - pixel_on = in_box && !gap && !blank && font_bit.
  - Font bit order: MSB = leftmost column.
- Blanking:
  - Digit values 4'hA..4'hF render as fully blank.
  - With BLANK_LZ=1:
    - dig_4 is blank if 0.
    - dig_3 is blank if dig_4 and dig_3 are both 0.
    - dig_2 is blank if dig_4, dig_3 and dig_2 are all 0.
  - Blanking is evaluated on the display registers.
- Latency:
  - Exactly 2 clk edges from hpos/vpos to pixel_on, independent of position.
  - A swap on frame_start affects pixels whose stage-2 lookup happens after the swap edge.
- Font (rows top to bottom, 3 bits each):
  - 0: 111 101 101 101 111
  - 1: 010 110 010 010 111
  - 2: 111 001 111 100 111
  - 3: 111 001 111 001 111
  - 4: 101 101 111 001 001
  - 5: 111 100 111 001 111
  - 6: 111 100 111 101 111
  - 7: 111 001 001 001 001
  - 8: 111 101 111 101 111
  - 9: 111 101 111 001 111

Decomposition:
- Shared package/include `bcd_render_pkg`:
  - Constants GLYPH_W=3, GLYPH_H=5, CELL_W=4, CELL_H=6, NUM_DIGITS=4.
  - The 10 font glyphs as 15-bit constants, row 0 in bits [14:12].
- Sub-module `digit_font_rom`: combinational; inputs digit[3:0] and row[2:0]; output bits[2:0]. Outputs 3'b000 for digits > 9 and rows > 4.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert reset while scanning the box, release it.
  - Required: pixel_on = 0 throughout; display = 0000, so the readout shows a single "0" in the dig_1 cell (x 352..383).
  - Check: pixel (352,200) lit at +2 cycles; (256,200) dark.
- Leading-zero blanking:
  - Stimulus: ready with digits 0,0,4,2, then frame_start.
  - Required: (256,200) and (288,200) -> 0; (320,200) -> 1 (top row of "4", column 0); (328,200) -> 0; (384,200) -> 0 (outside box).
- Tearing guard:
  - Stimulus: after a frame showing 0042, ready with 0,0,7,7 mid-frame.
  - Required: (328,200) stays 0 until the next frame_start; after it, (328,200) -> 1 (top row of "7" is 111).
- Simultaneous ready and frame_start:
  - Stimulus: assert both in one cycle carrying digits 0,0,0,1.
  - Required: display shows "1" immediately; (360,208) -> 1 (cell row 1 is 110, column 1 lit).
- Invalid digit and gaps:
  - Stimulus: dig_1 = 4'hA.
  - Required: the dig_1 cell is all 0.
  - Stimulus: "8" displayed.
  - Required: cell column 3 (x 344..351) and row 5 (y 240..247) are 0.
- Edge cases:
  - hpos = X0-1 and hpos = 0 -> 0; vpos = Y0+47 -> 0; vpos = Y0+39 is glyph row 4.
  - Latency measured as exactly 2 edges on a step from outside to inside the box.
